simple_threshold_udiv_24ns_10ns_16_seq: RTL and testbench

//   Sequential unsigned restoring divider; inverse of the 16x10->24 threshold multiplier.

---
 rtl/simple_threshold_pkg.sv | 22 ++
 rtl/simple_threshold_udiv_step.sv | 26 ++
 rtl/simple_threshold_udiv_24ns_10ns_16_seq.sv | 144 ++++++++++++++
 tb/tb_simple_threshold_udiv_24ns_10ns_16_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/simple_threshold_pkg.sv
// Shared constants and types for the threshold arithmetic path.
// Widths here are shared with the 16x10->24 threshold multiplier.
package simple_threshold_pkg;

   localparam int DIVIDEND_W = 24;
   localparam int DIVISOR_W  = 10;
   localparam int QUOTIENT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to count 0..qw inclusive
   function automatic int cnt_width(input int qw);
      return $clog2(qw + 1);
   endfunction

   localparam int CNT_W = cnt_width(QUOTIENT_W);

endpackage

// File: rtl/simple_threshold_udiv_step.sv
// Single restoring-division step: shift one dividend bit into the
// partial remainder and conditionally subtract the divisor.
module simple_threshold_udiv_step
   import simple_threshold_pkg::*;
#(
   parameter int W = DIVISOR_W
) (
   input  logic [W-1:0] prem,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] prem_next,
   output logic         q_bit
);

   logic [W:0] t;
   logic [W:0] dext;

   // Trial subtract; when t < divisor, t fits in W bits
   always_comb begin
      t         = {prem, bit_in};
      dext      = {1'b0, divisor};
      q_bit     = (t >= dext);
      prem_next = q_bit ? W'(t - dext) : t[W-1:0];
   end

endmodule

// File: rtl/simple_threshold_udiv_24ns_10ns_16_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Recovers quotient/remainder from a product-domain value and a scale.
module simple_threshold_udiv_24ns_10ns_16_seq
   import simple_threshold_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_W,
   parameter int DIVISOR_WIDTH  = DIVISOR_W,
   parameter int QUOTIENT_WIDTH = QUOTIENT_W
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero,
   output logic                      overflow
);

   localparam int HW = DIVIDEND_WIDTH - QUOTIENT_WIDTH;
   localparam int CW = cnt_width(QUOTIENT_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(QUOTIENT_WIDTH - 1);

   if (HW > DIVISOR_WIDTH) begin : g_bad_widths
      $error("dividend high part wider than divisor");
   end

   state_t                    state;
   state_t                    state_nx;
   logic [DIVISOR_WIDTH-1:0]  dsr;
   logic [DIVISOR_WIDTH-1:0]  prem;
   logic [QUOTIENT_WIDTH-1:0] dq;
   logic [CW-1:0]             cnt;

   logic                      accept;
   logic [DIVISOR_WIDTH-1:0]  hi;
   logic                      is_zero;
   logic                      is_ovf;
   logic [DIVISOR_WIDTH-1:0]  step_prem;
   logic                      step_q;
   logic [QUOTIENT_WIDTH-1:0] dq_nx;

   assign in_ready = (state == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign hi       = DIVISOR_WIDTH'(dividend >> QUOTIENT_WIDTH);
   assign is_zero  = (divisor == '0);
   assign is_ovf   = (hi >= divisor);
   assign dq_nx    = QUOTIENT_WIDTH'({dq, step_q});

   simple_threshold_udiv_step #(
      .W(DIVISOR_WIDTH)
   ) u_step (
      .prem      (prem),
      .bit_in    (dq[QUOTIENT_WIDTH-1]),
      .divisor   (dsr),
      .prem_next (step_prem),
      .q_bit     (step_q)
   );

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state <= ST_IDLE;
      else           state <= state_nx;
   end

   // Next-state: exceptions skip straight to DONE
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (accept)
               state_nx = (is_zero || is_ovf) ? ST_DONE : ST_CALC;
         end
         ST_CALC: begin
            if (cnt == LAST) state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Datapath: operand latch, iteration, and held result registers
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dsr         <= '0;
         prem        <= '0;
         dq          <= '0;
         cnt         <= '0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  dsr <= divisor;
                  if (is_zero) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                     out_valid   <= 1'b1;
                  end else if (is_ovf) begin
                     quotient  <= '1;
                     remainder <= '0;
                     overflow  <= 1'b1;
                     out_valid <= 1'b1;
                  end else begin
                     prem <= hi;
                     dq   <= dividend[QUOTIENT_WIDTH-1:0];
                     cnt  <= '0;
                  end
               end
            end
            ST_CALC: begin
               prem <= step_prem;
               dq   <= dq_nx;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  quotient  <= dq_nx;
                  remainder <= step_prem;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_threshold_udiv_24ns_10ns_16_seq.sv
// Scoreboard bench for the sequential threshold divider.
// Reference results come from native / and % on the operands.
module tb_simple_threshold_udiv_24ns_10ns_16_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] dividend = '0;
   logic [9:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] quotient;
   logic [9:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   typedef struct {
      logic [23:0] dvd;
      logic [9:0]  dsr;
      logic [15:0] q;
      logic [9:0]  r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;

   simple_threshold_udiv_24ns_10ns_16_seq dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [23:0] a,
                                  input logic [9:0] b);
      exp_t e;
      e.dvd = a;
      e.dsr = b;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (b == 0) begin
         e.q = 16'hFFFF; e.r = '0; e.dbz = 1'b1;
      end else if ({2'b0, a[23:16]} >= b) begin
         e.q = 16'hFFFF; e.r = '0; e.ovf = 1'b1;
      end else begin
         e.q = 16'(a / {14'b0, b});
         e.r = 10'(a % {14'b0, b});
      end
      return e;
   endfunction

   // Called #1 after a rising edge with the DUT idle
   task automatic run_op(input logic [23:0] a, input logic [9:0] b,
                         input int exp_lat, input int hold,
                         input bit inv);
      exp_t e;
      int   lat;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      sb.push_back(model(a, b));
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      dividend = 24'($urandom);
      divisor  = 10'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge ap_clk); #1;
         lat++;
      end
      if (exp_lat >= 0) check("latency", lat, exp_lat);
      else if (lat >= 40) check("timeout", lat, 0);
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         check("hold_valid", out_valid, 1);
         check("hold_q", quotient, e.q);
         check("hold_r", remainder, e.r);
         check("hold_ready", in_ready, 0);
         @(posedge ap_clk); #1;
      end
      in_valid = 1'b0;
      check("q", quotient, e.q);
      check("r", remainder, e.r);
      check("dbz", div_by_zero, e.dbz);
      check("ovf", overflow, e.ovf);
      check("ready_done", in_ready, 0);
      if (inv) begin
         check("inv", 64'(quotient) * 64'(e.dsr) + 64'(remainder),
               64'(e.dvd));
         check("r_lt_d", remainder < e.dsr, 1);
      end
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      check("idle_valid", out_valid, 0);
      check("idle_ready", in_ready, 1);
      check("idle_flags", {div_by_zero, overflow}, 0);
   endtask

   initial begin
      int  seen;
      int  d;
      int  h;
      #2;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_flags", {div_by_zero, overflow}, 0);
      repeat (3) @(posedge ap_clk);
      #1 ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      run_op(24'd1000000, 10'd1000, 16, 0, 1'b1);
      run_op(24'd16777215, 10'd1023, 16, 0, 1'b1);
      run_op(24'd12345, 10'd0, 0, 0, 1'b0);
      run_op(24'h100000, 10'd16, 0, 0, 1'b0);
      run_op(24'd7, 10'd3, 16, 5, 1'b1);

      // Reset during CALC with count at 8
      in_valid = 1'b1;
      dividend = 24'd1000000;
      divisor  = 10'd1000;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_q", quotient, 0);
      check("mid_rst_r", remainder, 0);
      check("mid_rst_ready", in_ready, 1);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge ap_clk); #1;
         if (out_valid) seen++;
      end
      check("discarded", seen, 0);
      check("post_rst_ready", in_ready, 1);
      run_op(24'd50, 10'd7, 16, 0, 1'b1);

      // Random non-exception operands
      for (int i = 0; i < 2000; i++) begin
         d = $urandom_range(1, 1023);
         h = $urandom_range(0, (d - 1 > 255) ? 255 : d - 1);
         run_op({8'(h), 16'($urandom)}, 10'(d), 16, 0, 1'b1);
      end

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
